collision_scanner: RTL and testbench



---
 rtl/collision_scanner_pkg.sv | 21 ++
 rtl/collision_scanner_aabb_overlap.sv | 34 +++
 rtl/collision_scanner.sv | 184 ++++++++++++++++++
 tb/tb_collision_scanner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_scanner_pkg.sv
// Shared definitions for the collision scanner: FSM state encodings, default
// tile/car geometry, default lane Y table and a port-width helper.
package collision_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_TILE_SIZE = 32;
    localparam int DEFAULT_CAR_W     = 32;

    // Lane 0 sits in the least significant Y field.
    localparam logic [53:0] DEFAULT_LANE_Y = {9'd320, 9'd288, 9'd256, 9'd192, 9'd160, 9'd128};

    function automatic int hit_lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/collision_scanner_aabb_overlap.sv
// Combinational frog-vs-car axis-aligned box overlap test; operands are widened
// by one bit so that position-plus-size sums cannot wrap.
module aabb_overlap #(
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int TILE_SIZE = 32,
    parameter int CAR_W     = 32
) (
    input  logic [X_W-1:0] frog_x_i,
    input  logic [Y_W-1:0] frog_y_i,
    input  logic [X_W-1:0] car_x_i,
    input  logic [Y_W-1:0] lane_y_i,
    output logic           hit_o
);

    localparam logic [X_W:0] TILE_X = TILE_SIZE[X_W:0];
    localparam logic [X_W:0] CAR_X  = CAR_W[X_W:0];
    localparam logic [Y_W:0] TILE_Y = TILE_SIZE[Y_W:0];

    logic [X_W:0] fx;
    logic [X_W:0] cx;
    logic [Y_W:0] fy;
    logic [Y_W:0] ly;

    assign fx = {1'b0, frog_x_i};
    assign cx = {1'b0, car_x_i};
    assign fy = {1'b0, frog_y_i};
    assign ly = {1'b0, lane_y_i};

    // Strict compares: boxes that only share an edge do not collide.
    assign hit_o = (fx < cx + CAR_X) && (cx < fx + TILE_X) &&
                   (fy < ly + TILE_Y) && (ly < fy + TILE_Y);

endmodule

// File: rtl/collision_scanner.sv
// Time-multiplexed frog-vs-car collision scanner: snapshots positions on a frame
// tick and tests one lane per clock. Optional hit counter: COLLISION_HIT_COUNT_EN.
module collision_scanner
    import collision_scanner_pkg::*;
#(
    parameter int                         NUM_LANES = 6,
    parameter int                         X_W       = 10,
    parameter int                         Y_W       = 9,
    parameter int                         TILE_SIZE = DEFAULT_TILE_SIZE,
    parameter int                         CAR_W     = DEFAULT_CAR_W,
    parameter logic [NUM_LANES*Y_W-1:0]   LANE_Y    = DEFAULT_LANE_Y
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Rst_L,
    input  logic                                 i_Start,
    input  logic                                 i_Clear,
    input  logic [X_W-1:0]                       i_Frog_X,
    input  logic [Y_W-1:0]                       i_Frog_Y,
    input  logic [NUM_LANES*X_W-1:0]             i_Car_X,
    output logic                                 o_Busy,
    output logic                                 o_Done,
    output logic                                 o_Has_Collided,
    output logic [hit_lane_w(NUM_LANES)-1:0]     o_Hit_Lane,
    output logic                                 o_Hit_Flag
`ifdef COLLISION_HIT_COUNT_EN
    ,
    output logic [7:0]                           o_Hit_Count
`endif
);

    localparam int              HL_W      = hit_lane_w(NUM_LANES);
    localparam logic [HL_W-1:0] LAST_LANE = HL_W'(NUM_LANES - 1);

    state_e                 state_q, state_d;
    logic                   take;
    logic [HL_W-1:0]        lane_q, lane_d;
    logic                   acc_hit_q, acc_hit_d;
    logic [HL_W-1:0]        acc_lane_q, acc_lane_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   has_q, has_d;
    logic [HL_W-1:0]        hit_lane_q, hit_lane_d;
    logic                   flag_q, flag_d;
    logic                   scan_hit;

    logic [X_W-1:0]           frog_x_q;
    logic [Y_W-1:0]           frog_y_q;
    logic [NUM_LANES*X_W-1:0] car_x_q;
    logic [X_W-1:0]           car_x_sel;
    logic [Y_W-1:0]           lane_y_sel;
    logic                     lane_hit;

    assign car_x_sel  = car_x_q[int'(lane_q)*X_W +: X_W];
    assign lane_y_sel = LANE_Y[int'(lane_q)*Y_W +: Y_W];

    aabb_overlap #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .TILE_SIZE(TILE_SIZE),
        .CAR_W    (CAR_W)
    ) u_overlap (
        .frog_x_i (frog_x_q),
        .frog_y_i (frog_y_q),
        .car_x_i  (car_x_sel),
        .lane_y_i (lane_y_sel),
        .hit_o    (lane_hit)
    );

    always_comb begin
        state_d    = state_q;
        take       = 1'b0;
        lane_d     = lane_q;
        acc_hit_d  = acc_hit_q;
        acc_lane_d = acc_lane_q;
        done_d     = 1'b0;
        has_d      = has_q;
        hit_lane_d = hit_lane_q;
        flag_d     = i_Clear ? 1'b0 : flag_q;
        scan_hit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take = i_Start;
            end
            ST_SCAN: begin
                if (lane_hit && !acc_hit_q) begin
                    acc_hit_d  = 1'b1;
                    acc_lane_d = lane_q;
                end
                if (lane_q == LAST_LANE) begin
                    // Final lane folds straight into the registered result so it is
                    // valid in the same cycle that o_Done is high.
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    scan_hit   = acc_hit_q | lane_hit;
                    has_d      = scan_hit;
                    hit_lane_d = acc_hit_q ? acc_lane_q : (lane_hit ? lane_q : '0);
                    if (scan_hit) begin
                        flag_d = 1'b1;
                    end
                end else begin
                    lane_d = lane_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                take    = i_Start;
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            state_d    = ST_SCAN;
            lane_d     = '0;
            acc_hit_d  = 1'b0;
            acc_lane_d = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q    <= ST_IDLE;
            lane_q     <= '0;
            acc_hit_q  <= 1'b0;
            acc_lane_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            has_q      <= 1'b0;
            hit_lane_q <= '0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            acc_hit_q  <= acc_hit_d;
            acc_lane_q <= acc_lane_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            has_q      <= has_d;
            hit_lane_q <= hit_lane_d;
            flag_q     <= flag_d;
        end
    end

    // Snapshot is pure data, qualified by the FSM, so it carries no reset.
    always_ff @(posedge i_Clk) begin
        if (take) begin
            frog_x_q <= i_Frog_X;
            frog_y_q <= i_Frog_Y;
            car_x_q  <= i_Car_X;
        end
    end

`ifdef COLLISION_HIT_COUNT_EN
    logic [7:0] count_q, count_d;
    logic [7:0] count_base;

    always_comb begin
        count_base = i_Clear ? 8'd0 : count_q;
        count_d    = count_base;
        if (scan_hit && count_base != 8'hFF) begin
            count_d = count_base + 8'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_Hit_Count = count_q;
`endif

    assign o_Busy         = busy_q;
    assign o_Done         = done_q;
    assign o_Has_Collided = has_q;
    assign o_Hit_Lane     = hit_lane_q;
    assign o_Hit_Flag     = flag_q;

endmodule

// File: tb/tb_collision_scanner.sv
// Randomized self-checking bench for collision_scanner against a lane-table
// reference model; exercises the hit counter when COLLISION_HIT_COUNT_EN is set.
module tb_collision_scanner;

    localparam int NL = 6;
    localparam int XW = 10;
    localparam int YW = 9;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            clr;
    logic [XW-1:0]   fx;
    logic [YW-1:0]   fy;
    logic [NL*XW-1:0] carx;
    logic            busy;
    logic            done;
    logic            has;
    logic [2:0]      hl;
    logic            flag;
`ifdef COLLISION_HIT_COUNT_EN
    logic [7:0]      cnt;
`endif

    always #5 clk = ~clk;

    collision_scanner dut (
        .i_Clk          (clk),
        .i_Rst_L        (rst_n),
        .i_Start        (start),
        .i_Clear        (clr),
        .i_Frog_X       (fx),
        .i_Frog_Y       (fy),
        .i_Car_X        (carx),
        .o_Busy         (busy),
        .o_Done         (done),
        .o_Has_Collided (has),
        .o_Hit_Lane     (hl),
        .o_Hit_Flag     (flag)
`ifdef COLLISION_HIT_COUNT_EN
        ,
        .o_Hit_Count    (cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int lane_y_tab[NL] = '{128, 160, 192, 256, 288, 320};
    int cars[NL];
    bit m_flag = 1'b0;
    int m_cnt  = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer box test per lane, first hit wins.
    function automatic void ref_scan(input int x, input int y, output bit hit, output int lane);
        hit  = 1'b0;
        lane = 0;
        for (int k = 0; k < NL; k++) begin
            if (!hit && x < cars[k] + 32 && cars[k] < x + 32 &&
                y < lane_y_tab[k] + 32 && lane_y_tab[k] < y + 32) begin
                hit  = 1'b1;
                lane = k;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int x, input int y);
        fx = XW'(x);
        fy = YW'(y);
        for (int k = 0; k < NL; k++) carx[k*XW +: XW] = XW'(cars[k]);
    endtask

    task automatic check_count(input string tag);
`ifdef COLLISION_HIT_COUNT_EN
        check(tag, cnt, m_cnt);
`endif
    endtask

    task automatic run_scan(input string tag, input int x, input int y,
                            input bit clr_last, input bit scramble);
        bit e_hit;
        int e_lane;
        int cyc;
        bit got_done;
        int base;
        ref_scan(x, y, e_hit, e_lane);
        load(x, y);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        got_done = 1'b0;
        while (cyc <= NL + 4) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (cyc == 1) check({tag, ":busy"}, busy, 1);
            if (scramble) begin
                fx = XW'($urandom);
                fy = YW'($urandom);
                for (int k = 0; k < NL; k++) carx[k*XW +: XW] = XW'($urandom);
            end
            clr = (clr_last && cyc == NL);
            tick();
            cyc++;
        end
        clr = 1'b0;
        check({tag, ":latency"}, got_done ? cyc : 0, NL + 1);
        if (got_done) begin
            if (e_hit) m_flag = 1'b1;
            else if (clr_last) m_flag = 1'b0;
            base = clr_last ? 0 : m_cnt;
            if (e_hit && base < 255) base++;
            m_cnt = base;
            check({tag, ":has"}, has, e_hit);
            check({tag, ":lane"}, hl, e_lane);
            check({tag, ":flag"}, flag, m_flag);
            check({tag, ":busy_done"}, busy, 1);
            check_count({tag, ":count"});
        end
    endtask

    task automatic far_cars();
        for (int k = 0; k < NL; k++) cars[k] = 700;
    endtask

    initial begin
        int dones;
        int v;
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        fx    = '0;
        fy    = '0;
        carx  = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_has", has, 0);
        check("rst_lane", hl, 0);
        check("rst_flag", flag, 0);
        check_count("rst_count");
        rst_n = 1'b1;
        tick();

        far_cars();
        cars[0] = 90;
        run_scan("basic", 100, 128, 1'b0, 1'b0);
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        far_cars();
        cars[1] = 120;
        cars[2] = 110;
        run_scan("multi", 100, 170, 1'b0, 1'b0);
        tick();

        clr = 1'b1;
        tick();
        clr = 1'b0;
        m_flag = 1'b0;
        m_cnt  = 0;
        check("clear_flag", flag, 0);
        check_count("clear_count");

        far_cars();
        cars[0] = 100;
        run_scan("edge_touch", 132, 128, 1'b0, 1'b0);
        tick();
        cars[0] = 101;
        run_scan("edge_overlap", 132, 128, 1'b0, 1'b0);
        tick();

        far_cars();
        cars[0] = 1000;
        run_scan("nowrap_hit", 1000, 128, 1'b0, 1'b0);
        tick();
        run_scan("nowrap_miss", 0, 128, 1'b0, 1'b0);
        tick();

        // Start pulse during the scan must not produce a second result.
        far_cars();
        cars[0] = 90;
        load(100, 128);
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int c = 1; c <= 2 * NL + 6; c++) begin
            start = (c == 3);
            if (c == 3) load(600, 400);
            if (done) begin
                dones++;
                check("busy_ign_has", has, 1);
                check("busy_ign_lane", hl, 0);
            end
            tick();
        end
        start = 1'b0;
        check("busy_ign_dones", dones, 1);
        m_flag = 1'b1;
        if (m_cnt < 255) m_cnt++;

        // Asynchronous reset in the middle of a scan.
        load(100, 128);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_has", has, 0);
        check("midrst_lane", hl, 0);
        check("midrst_flag", flag, 0);
        m_flag = 1'b0;
        m_cnt  = 0;
        check_count("midrst_count");
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < NL + 4; c++) begin
            if (done) dones++;
            tick();
        end
        check("midrst_nodone", dones, 0);

        for (int i = 0; i < 40; i++) begin
            int x;
            int y;
            x = int'($urandom_range(0, 1023));
            y = int'($urandom_range(100, 360));
            for (int k = 0; k < NL; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    v = x + int'($urandom_range(0, 80)) - 40;
                    if (v < 0) v = 0;
                    if (v > 1023) v = 1023;
                    cars[k] = v;
                end else begin
                    cars[k] = int'($urandom_range(0, 1023));
                end
            end
            run_scan("rand", x, y, $urandom_range(0, 3) == 0, 1'b1);
            if ($urandom_range(0, 2) != 0) begin
                tick();
                check("rand_idle_busy", busy, 0);
                if ($urandom_range(0, 3) == 0) begin
                    clr = 1'b1;
                    tick();
                    clr = 1'b0;
                    m_flag = 1'b0;
                    m_cnt  = 0;
                    check("rand_clear_flag", flag, 0);
                end
            end
        end
        tick();

`ifdef COLLISION_HIT_COUNT_EN
        far_cars();
        cars[0] = 90;
        for (int i = 0; i < 300; i++) begin
            run_scan("sat", 100, 128, 1'b0, 1'b0);
            tick();
        end
        check("sat_count", cnt, 255);
        run_scan("clr_hit", 100, 128, 1'b1, 1'b0);
        check("clr_hit_count", cnt, 1);
        check("clr_hit_flag", flag, 1);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
